// File: rtl/uart_tx_arbiter.sv
// Round-robin whole-frame arbiter in front of one uart_tx serializer, with a fixed idle gap
// after each byte. Define UART_ARB_TIMEOUT_EN to abort frames that stall in LOAD/WAIT_DONE.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   byte_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   frame_done,
  output logic [NUM_REQ-1:0]   frame_abort,
  output logic                 arb_busy,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_done,
  input  logic                 uart_tx_busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {ARB, LOAD, WAIT_DONE, GAP} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [15:0]          gap_cnt_q, gap_cnt_d;
  logic                 last_q, last_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   byte_ack_q, byte_ack_d;
  logic [NUM_REQ-1:0]   frame_done_q, frame_done_d;
  logic                 uart_tx_en_q, uart_tx_en_d;
  logic [7:0]           uart_tx_data_q, uart_tx_data_d;
`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0]          stall_cnt_q, stall_cnt_d;
  logic [NUM_REQ-1:0]   frame_abort_q, frame_abort_d;
`endif

  logic                 pick_found;
  logic [IW-1:0]        pick_idx;

  // Scan from farthest to nearest so the requester just after rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    gidx_d         = gidx_q;
    gap_cnt_d      = gap_cnt_q;
    last_d         = last_q;
    grant_d        = grant_q;
    uart_tx_data_d = uart_tx_data_q;
    byte_ack_d     = '0;
    frame_done_d   = '0;
    uart_tx_en_d   = 1'b0;
    case (state_q)
      ARB: begin
        if (pick_found && !uart_tx_busy) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (req_valid[gidx_q]) begin
          uart_tx_data_d = req_data[8*int'(gidx_q) +: 8];
          last_d         = req_last[gidx_q];
          uart_tx_en_d   = 1'b1;
          byte_ack_d     = grant_q;
          state_d        = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (uart_tx_done) begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == 16'(GAP_CYCLES - 1)) begin
          if (last_q) begin
            frame_done_d = grant_q;
            rr_ptr_d     = gidx_q;
            grant_d      = '0;
            state_d      = ARB;
          end else begin
            state_d = LOAD;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = ARB;
    endcase
`ifdef UART_ARB_TIMEOUT_EN
    // Counts only cycles that are actually stalled; any byte load or done clears it.
    stall_cnt_d   = '0;
    frame_abort_d = '0;
    if ((state_q == LOAD && !req_valid[gidx_q]) || (state_q == WAIT_DONE && !uart_tx_done)) begin
      if (stall_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
        frame_abort_d = grant_q;
        grant_d       = '0;
        rr_ptr_d      = gidx_q;
        state_d       = ARB;
      end else begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARB;
      rr_ptr_q       <= IW'(NUM_REQ - 1);
      gidx_q         <= '0;
      gap_cnt_q      <= '0;
      last_q         <= 1'b0;
      grant_q        <= '0;
      byte_ack_q     <= '0;
      frame_done_q   <= '0;
      uart_tx_en_q   <= 1'b0;
      uart_tx_data_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt_q    <= '0;
      frame_abort_q  <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      gidx_q         <= gidx_d;
      gap_cnt_q      <= gap_cnt_d;
      last_q         <= last_d;
      grant_q        <= grant_d;
      byte_ack_q     <= byte_ack_d;
      frame_done_q   <= frame_done_d;
      uart_tx_en_q   <= uart_tx_en_d;
      uart_tx_data_q <= uart_tx_data_d;
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt_q    <= stall_cnt_d;
      frame_abort_q  <= frame_abort_d;
`endif
    end
  end

  assign grant        = grant_q;
  assign byte_ack     = byte_ack_q;
  assign frame_done   = frame_done_q;
  assign uart_tx_en   = uart_tx_en_q;
  assign uart_tx_data = uart_tx_data_q;
  assign arb_busy     = (state_q != ARB);
`ifdef UART_ARB_TIMEOUT_EN
  assign frame_abort  = frame_abort_q;
`else
  // Evaluates to 0 for every legal TIMEOUT_CYCLES; no abort path exists in this build.
  assign frame_abort  = {NUM_REQ{TIMEOUT_CYCLES < 1}};
`endif

endmodule
